// File: rtl/risc_me_pkg.sv
// Shared types and defaults for the load/store byte sequencer.
package risc_me_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 8;
  localparam int unsigned DATA_W_DEFAULT = 16;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_HALF = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StAcc0,
    StAcc1,
    StCapt,
    StDone
  } lsu_state_e;

endpackage

// File: rtl/lsu_byte_sequencer.sv
// Byte/halfword load-store sequencer in front of a 256x8 synchronous memory.
// Optional byte-load sign extension is enabled by defining LSU_SIGNEXT_EN.
module lsu_byte_sequencer
  import risc_me_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic              write_q, write_d;
  logic              size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

`ifdef LSU_SIGNEXT_EN
  logic signed_q, signed_d;
`else
  logic unused_signed;
  assign unused_signed = req_signed;
`endif

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
`ifdef LSU_SIGNEXT_EN
    signed_d    = signed_q;
`endif
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_rdata  = '0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d  = req_write;
          size_d   = req_size;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = '0;  // byte loads rely on the upper byte starting clear
`ifdef LSU_SIGNEXT_EN
          signed_d = req_signed;
`endif
          state_d  = StAcc0;
        end
      end
      StAcc0: begin
        mem_address = addr_q;
        mem_wdata   = wdata_q[7:0];
        mem_write   = write_q;
        if (size_q == SIZE_HALF) begin
          state_d = StAcc1;
        end else if (write_q) begin
          state_d = StDone;
        end else begin
          state_d = StCapt;
        end
      end
      StAcc1: begin
        mem_address = addr_q + ADDR_W'(1);
        mem_wdata   = wdata_q[15:8];
        mem_write   = write_q;
        // Read data for the ACC0 address lands this cycle.
        if (!write_q) begin
          rdata_d[7:0] = mem_rdata;
        end
        state_d = write_q ? StDone : StCapt;
      end
      StCapt: begin
        if (size_q == SIZE_HALF) begin
          rdata_d[15:8] = mem_rdata;
        end else begin
          rdata_d[7:0] = mem_rdata;
        end
        state_d = StDone;
      end
      StDone: begin
        resp_valid = 1'b1;
        if (!write_q) begin
          resp_rdata = rdata_q;
`ifdef LSU_SIGNEXT_EN
          if (size_q == SIZE_BYTE && signed_q) begin
            resp_rdata[15:8] = {8{rdata_q[7]}};
          end
`endif
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      write_q  <= 1'b0;
      size_q   <= SIZE_BYTE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
`ifdef LSU_SIGNEXT_EN
      signed_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
`ifdef LSU_SIGNEXT_EN
      signed_q <= signed_d;
`endif
    end
  end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Self-checking bench for lsu_byte_sequencer with a 256x8 registered-read memory model.
module tb_lsu_byte_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_size, req_signed;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        mem_write;
  logic [7:0]  mem_address, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  lsu_byte_sequencer #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .mem_write  (mem_write),
    .mem_address(mem_address),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: write on the edge, read data registered (old data on collision).
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= mem_wdata;
    mem_rdata <= mem[mem_address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a request accepted at edge T occupies cycles k=1..lat after it,
  // byte i is presented in cycle k=1+i, and the response appears in cycle k=lat.
  logic [7:0]  ref_mem [256];
  bit          m_busy = 1'b0;
  int          m_k = 0;
  int          m_lat = 0;
  logic        m_w = 1'b0, m_h = 1'b0;
  logic [7:0]  m_a = '0, m_a1;
  logic [15:0] m_wd = '0, m_rd = '0;
  logic [7:0]  m_ext;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_k    = 0;
    end else if (m_busy) begin
      m_a1 = m_a + 8'd1;
      if (m_w && m_k == 1) ref_mem[m_a] = m_wd[7:0];
      if (m_w && m_h && m_k == 2) ref_mem[m_a1] = m_wd[15:8];
      if (m_k == m_lat) begin
        m_busy = 1'b0;
        m_k    = 0;
      end else begin
        m_k++;
      end
    end else if (req_valid) begin
      m_w   = req_write;
      m_h   = req_size;
      m_a   = req_addr;
      m_wd  = req_wdata;
      m_a1  = m_a + 8'd1;
      m_lat = 2 + (m_h ? 1 : 0) + (m_w ? 0 : 1);
      m_ext = 8'h00;
`ifdef LSU_SIGNEXT_EN
      if (req_signed && ref_mem[m_a][7]) m_ext = 8'hFF;
`endif
      if (m_w) m_rd = 16'h0000;
      else if (m_h) m_rd = {ref_mem[m_a1], ref_mem[m_a]};
      else m_rd = {m_ext, ref_mem[m_a]};
      m_busy = 1'b1;
      m_k    = 1;
    end
  end

  always @(negedge clk) begin
    logic        e_rv, e_we;
    logic [7:0]  e_addr, e_wd;
    e_rv   = m_busy && (m_k == m_lat);
    e_we   = m_busy && m_w && (m_k == 1 || (m_h && m_k == 2));
    e_addr = 8'h00;
    e_wd   = 8'h00;
    if (m_busy && m_k == 1) begin
      e_addr = m_a;
      e_wd   = m_wd[7:0];
    end else if (m_busy && m_h && m_k == 2) begin
      e_addr = m_a + 8'd1;
      e_wd   = m_wd[15:8];
    end
    check("req_ready", 32'(req_ready), 32'(!m_busy));
    check("resp_valid", 32'(resp_valid), 32'(e_rv));
    check("resp_rdata", 32'(resp_rdata), e_rv ? 32'(m_rd) : 32'h0);
    check("mem_write", 32'(mem_write), 32'(e_we));
    check("mem_address", 32'(mem_address), 32'(e_addr));
    check("mem_wdata", 32'(mem_wdata), 32'(e_wd));
  end

  // Issue one request from an idle DUT (called at #1 after an edge); returns response data,
  // response latency in cycles after acceptance, and the number of write-enable cycles.
  task automatic run_req(input logic w, input logic h, input logic sg, input logic [7:0] a,
                         input logic [15:0] wd, output logic [15:0] rd, output int lat,
                         output int wcnt);
    int  n;
    bit  acc, got;
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = h;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    n = 0;
    do begin
      acc = req_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 20);
    req_valid = 1'b0;
    check("accept_timeout", 32'(acc), 32'h1);
    n    = 1;
    got  = 1'b0;
    wcnt = 0;
    rd   = '0;
    lat  = 0;
    while (!got && n < 20) begin
      if (mem_write) wcnt++;
      if (resp_valid) begin
        got = 1'b1;
        rd  = resp_rdata;
        lat = n;
      end
      @(posedge clk);
      #1;
      n++;
    end
    check("resp_timeout", 32'(got), 32'h1);
  endtask

  logic [15:0] rd;
  int          lat, wc, idx, pulses, diffs;
  bit          prev_ready;

  task automatic set_hs(input int i);
    case (i)
      0: begin req_write = 1'b1; req_size = 1'b1; req_addr = 8'h60; req_wdata = 16'h7711; end
      1: begin req_write = 1'b0; req_size = 1'b0; req_addr = 8'h60; req_wdata = 16'h0000; end
      default: begin req_write = 1'b1; req_size = 1'b0; req_addr = 8'h62; req_wdata = 16'h0099; end
    endcase
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     <= 8'(i) ^ 8'h5A;
      ref_mem[i]  = 8'(i) ^ 8'h5A;
    end
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 1'b0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    #1;
    check("rst_ready", 32'(req_ready), 32'h1);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_rdata", 32'(resp_rdata), 32'h0);
    check("rst_mem_write", 32'(mem_write), 32'h0);
    check("rst_mem_address", 32'(mem_address), 32'h0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Byte store then byte load.
    run_req(1'b1, 1'b0, 1'b0, 8'h10, 16'h00A5, rd, lat, wc);
    check("bst_latency", 32'(lat), 32'd2);
    check("bst_wcycles", 32'(wc), 32'd1);
    check("bst_mem10", 32'(mem[8'h10]), 32'hA5);
    run_req(1'b0, 1'b0, 1'b0, 8'h10, 16'h0000, rd, lat, wc);
    check("bld_rdata", 32'(rd), 32'h00A5);
    check("bld_latency", 32'(lat), 32'd3);
    check("bld_wcycles", 32'(wc), 32'd0);

    // Halfword round trip.
    run_req(1'b1, 1'b1, 1'b0, 8'h20, 16'hBEEF, rd, lat, wc);
    check("hst_latency", 32'(lat), 32'd3);
    check("hst_wcycles", 32'(wc), 32'd2);
    check("hst_mem20", 32'(mem[8'h20]), 32'hEF);
    check("hst_mem21", 32'(mem[8'h21]), 32'hBE);
    run_req(1'b0, 1'b1, 1'b1, 8'h20, 16'h0000, rd, lat, wc);
    check("hld_rdata", 32'(rd), 32'hBEEF);
    check("hld_latency", 32'(lat), 32'd4);

    // Address wrap.
    run_req(1'b1, 1'b1, 1'b0, 8'hFF, 16'h1234, rd, lat, wc);
    check("wrap_memFF", 32'(mem[8'hFF]), 32'h34);
    check("wrap_mem00", 32'(mem[8'h00]), 32'h12);
    run_req(1'b0, 1'b1, 1'b0, 8'hFF, 16'h0000, rd, lat, wc);
    check("wrap_rdata", 32'(rd), 32'h1234);

    // Back-to-back requests with req_valid held high.
    idx = 0;
    pulses = 0;
    req_valid = 1'b1;
    req_signed = 1'b0;
    set_hs(0);
    prev_ready = req_ready;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (prev_ready && idx < 3) begin
        idx++;
        if (idx < 3) set_hs(idx);
        else req_valid = 1'b0;
      end
      if (resp_valid) pulses++;
      prev_ready = req_ready;
    end
    check("hs_accepts", 32'(idx), 32'd3);
    check("hs_pulses", 32'(pulses), 32'd3);
    check("hs_mem62", 32'(mem[8'h62]), 32'h99);

    // Reset during the second byte of a halfword store.
    req_valid = 1'b1; req_write = 1'b1; req_size = 1'b1; req_addr = 8'h40;
    req_wdata = 16'hCAFE;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_ready", 32'(req_ready), 32'h1);
    check("abort_mem_write", 32'(mem_write), 32'h0);
    check("abort_resp_valid", 32'(resp_valid), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (resp_valid) pulses++;
    end
    check("abort_no_resp", 32'(pulses), 32'd0);
    check("abort_mem40", 32'(mem[8'h40]), 32'hFE);
    check("abort_mem41", 32'(mem[8'h41]), 32'h1B);

    // Sign extension of byte loads.
    run_req(1'b1, 1'b0, 1'b0, 8'h50, 16'h0080, rd, lat, wc);
    run_req(1'b0, 1'b0, 1'b1, 8'h50, 16'h0000, rd, lat, wc);
`ifdef LSU_SIGNEXT_EN
    check("sext_signed", 32'(rd), 32'hFF80);
`else
    check("sext_signed", 32'(rd), 32'h0080);
`endif
    run_req(1'b0, 1'b0, 1'b0, 8'h50, 16'h0000, rd, lat, wc);
    check("sext_unsigned", 32'(rd), 32'h0080);

    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check("mem_image_diffs", 32'(diffs), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_byte_sequencer.md
Name: lsu_byte_sequencer

Overview:
- Load/store sequencer between the core datapath and the 256x8 synchronous data memory.
- Accepts one byte or halfword request at a time over a valid/ready handshake.
- Drives the memory's write-enable, address and write-data one byte per cycle, little-endian.
- Collects read bytes that arrive one cycle after their address and returns a single-cycle response pulse.

Parameters:
- ADDR_W, 8, byte address width; matches the memory depth of 256.
- DATA_W, 16, request/response data width (two bytes).

Ports:
- clk  in  1  rising-edge clock shared with the memory
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  1  0 = byte, 1 = halfword
- req_signed  in  1  load sign-extension select; used only with LSU_SIGNEXT_EN
- req_addr  in  ADDR_W  byte address of the lowest byte
- req_wdata  in  DATA_W  store data; [7:0] goes to addr, [15:8] to addr+1
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  load result; 0 for stores
- mem_write  out  1  memory write enable
- mem_address  out  ADDR_W  memory address
- mem_wdata  out  8  memory write byte
- mem_rdata  in  8  memory registered read byte; reflects the address presented in the previous cycle

Behaviour:
- Reset (async, while rst high):
  - state = IDLE; req_ready = 1; resp_valid = 0; resp_rdata = 0.
  - mem_write = 0; mem_address = 0; mem_wdata = 0.
  - All latched request fields clear.
- States: IDLE, ACC0, ACC1, CAPT, DONE. Memory outputs decode combinationally from the state and latched registers.
- IDLE:
  - On req_valid, latch write, size, signed, addr and wdata; go to ACC0.
  - req_valid is ignored outside IDLE; there is no queueing.
- ACC0:
  - mem_address = addr_q; mem_wdata = wdata_q[7:0]; mem_write = write_q.
  - Next: ACC1 if halfword; else DONE if store; else CAPT.
- ACC1:
  - mem_address = addr_q + 1, modulo 2^ADDR_W, so 0xFF wraps to 0x00. mem_wdata = wdata_q[15:8]; mem_write = write_q.
  - Load: capture mem_rdata into rdata_q[7:0].
  - Next: DONE if store, else CAPT.
- CAPT:
  - mem_write = 0; mem_address = 0.
  - Capture mem_rdata into rdata_q[15:8] for a halfword, or rdata_q[7:0] for a byte. Next: DONE.
- DONE:
  - resp_valid = 1 for exactly one cycle; resp_rdata valid in the same cycle. Next: IDLE.
  - Byte load: resp_rdata[15:8] = 0 unless sign-extension applies.
  - resp_rdata returns to 0 in IDLE.
- Latency, counted from the acceptance edge at cycle T:
  - byte store: DONE at T+2
  - byte load: DONE at T+3
  - halfword store: DONE at T+3
  - halfword load: DONE at T+4
- Throughput: the next request is accepted in the cycle after DONE.
- resp_valid has no back-pressure; the consumer must take it.
- The sequencer never reads the byte it is writing in the same cycle. The memory returns old data on read-during-write, and the design relies on that never happening.
- Reset mid-operation:
  - The state drops to IDLE immediately and mem_write falls combinationally.
  - A byte whose write edge coincides with rst high is not written; bytes already written stay written.
  - No response is issued for the aborted request.
- Only state, the latched request fields and rdata_q are registered.

Optional Feature:
- Macro: LSU_SIGNEXT_EN.
- Defined: for a byte load with req_signed = 1, resp_rdata[15:8] = {8{rdata_q[7]}}. Halfword loads and stores are unaffected.
- Undefined: req_signed is ignored and byte loads are always zero-extended. The port stays present so the interface is identical.

Decomposition:
- Shared package risc_me_pkg holds:
  - the state enum (IDLE, ACC0, ACC1, CAPT, DONE)
  - the size constants SIZE_BYTE = 0 and SIZE_HALF = 1
  - ADDR_W and DATA_W defaults
- No sub-module; the FSM and byte steering live in one module.
- The bench instantiates it with the existing memory block.

Test Plan:
- Byte store then byte load: store 0xA5 to 0x10, then load 0x10 -> resp_rdata = 0x00A5. Response at T+2 for the store and T+3 for the load; mem_write high exactly 1 cycle.
- Halfword round trip: store 0xBEEF to 0x20, then load -> mem[0x20] = 0xEF, mem[0x21] = 0xBE, resp_rdata = 0xBEEF at T+4.
- Wrap-around: halfword store 0x1234 to 0xFF -> mem[0xFF] = 0x34, mem[0x00] = 0x12; halfword load of 0xFF returns 0x1234.
- Handshake: hold req_valid high continuously with 3 queued requests -> req_ready low from ACC0 through DONE, each request accepted once, resp_valid pulses exactly 3 times.
- Reset mid-op: assert rst during ACC1 of a halfword store of 0xCAFE to 0x40 -> mem[0x40] = 0xFE, mem[0x41] unchanged, no resp_valid, req_ready = 1 immediately.
- Sign extension: mem[0x50] = 0x80, byte load with req_signed = 1 -> 0xFF80 with LSU_SIGNEXT_EN defined, 0x0080 without.
